registrador_ctrl: RTL and testbench
===================================

Name: registrador_ctrl

Overview:
Controller that shares one 4-bit registrador (clk, d, q; no enable) between N requesters. It arbitrates write requests round-robin and drives the registrador's d. It reads back q one cycle after capture and returns a per-transaction ack with a verify error flag. Between transactions it holds d constant, so the registrador keeps its content.

Parameters:
N, 4, number of requesters (2..8)
W, 4, data width of the shared registrador
IDXW, $clog2(N), width of the requester index

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
req  in  N  write request per requester; level, held until ack
wdata  in  N*W  write data; requester i occupies bits [i*W +: W]; stable while req[i]=1
ack  out  N  one-cycle completion pulse to the granted requester
err  out  1  verify mismatch for the current ack; valid only while ack != 0
err_sticky  out  1  set by any mismatch; cleared by err_clr or reset
err_clr  in  1  synchronous clear of err_sticky
reg_d  out  W  to registrador d
reg_q  in  W  from registrador q
busy  out  1  transaction in progress (state != IDLE)
owner  out  IDXW  index of the granted requester; valid while busy

Behaviour:
- Reset (rst=0, async): state=IDLE; reg_d=0; ack=0; err=0; err_sticky=0; owner=0; rr pointer=0.
- All outputs are registered. busy is decoded from the state register.
- FSM states: IDLE -> WRITE -> VERIFY -> RELEASE -> IDLE.
- IDLE: if req != 0, pick the winner round-robin. Search starts at the pointer and goes upward, wrapping N-1 -> 0. At the edge: owner<=winner, reg_d<=wdata[winner], state<=WRITE. If req == 0, stay in IDLE and hold reg_d.
- WRITE: reg_d is stable, and the registrador captures it at the end of this cycle. Next state is VERIFY.
- VERIFY: compare reg_q with reg_d. At the edge: ack[owner]<=1, err<=(reg_q!=reg_d), err_sticky<=err_sticky|mismatch, state<=RELEASE.
- RELEASE: ack is high for exactly this cycle. At the edge: ack<=0, err<=0, pointer<=(owner+1) mod N, state<=IDLE.
- Latency: req sampled in IDLE (cycle 0) gives ack high in cycle 3. One transaction takes 4 cycles. A requester still asserting req is re-eligible in the next IDLE cycle, behind the others by rotation.
- Fairness: with all req high, grants follow 0,1,2,...,N-1,0,... No requester waits more than N transactions.
- req dropped after grant: the transaction still completes with the latched owner. reg_d was latched in IDLE, so later wdata changes are ignored. ack is still pulsed.
- New req arriving while busy: ignored until the next IDLE.
- err_clr and a mismatch in the same cycle: the mismatch wins, so err_sticky=1.
- reg_d is never changed outside the IDLE->WRITE edge, so the registrador content is preserved.
- Reset mid-transaction: immediate return to IDLE and reg_d=0. No ack is issued. The registrador is loaded with 0 on the following edge.

Decomposition:
- Package registrador_pkg:
  - typedef enum logic[1:0] {IDLE, WRITE, VERIFY, RELEASE} ctrl_state_t
  - localparam REG_W=4
- Sub-module rr_arbitro: purely combinational round-robin picker.
  - Inputs: req[N], pointer.
  - Outputs: winner[IDXW], any.
  - Implementation: double-width rotate and priority encode.

Test Plan:
- Reset with rst=0 for 12 ns, then release: reg_d=0, busy=0, ack=0, err_sticky=0; with req=0 reg_d stays 0 for 20 cycles.
- Single req[2] with wdata[2]=4'b1010: owner=2 and reg_d=1010 in cycle 1; reg_q=1010 in cycle 2; ack=4'b0100 in cycle 3 with err=0; busy=0 in cycle 4.
- All req=4'b1111, each holding until its own ack then reasserting, with wdata[i]=i+5: grant order 0,1,2,3,0; reg_q sequence 0101,0110,0111,1000,0101.
- Force reg_q to 0000 during VERIFY on a write of 1111: err=1 with ack; err_sticky=1 and held. Pulse err_clr: err_sticky=0.
- req[1] dropped in WRITE: ack[1] still pulses in cycle 3 and reg_d keeps the latched value. Changing wdata[1] mid-transaction has no effect on reg_d.
- Assert rst=0 during VERIFY: busy=0 and reg_d=0 immediately; no ack. After release, a pending req[3] is granted first (pointer=0, only req[3] set).

Source files
------------

// File: rtl/registrador_pkg.sv
// Shared types for the registrador write/verify controller.
package registrador_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        VERIFY  = 2'd2,
        RELEASE = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/rr_arbitro.sv
// Combinational round-robin picker: the search starts at ptr and moves
// upward, wrapping from N-1 to 0.
module rr_arbitro #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] winner,
    output logic            any
);

    localparam logic [IDXW:0] N_L = (IDXW+1)'(N);

    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [IDXW-1:0] off;
    logic [IDXW:0]   sum;

    // Doubling req makes a plain part-select behave as a rotate right by ptr.
    assign dbl = {req, req};
    assign rot = dbl[ptr +: N];
    assign any = |req;

    always_comb begin
        off = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (rot[i]) off = IDXW'(i);
        end
    end

    assign sum    = {1'b0, ptr} + {1'b0, off};
    assign winner = (sum >= N_L) ? IDXW'(sum - N_L) : sum[IDXW-1:0];

endmodule

// File: rtl/registrador_ctrl.sv
// Shares one W-bit registrador between N requesters: round-robin write,
// read back one cycle after capture, ack with a verify flag.
module registrador_ctrl
    import registrador_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = REG_W,
    parameter int IDXW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    wdata,
    output logic [N-1:0]      ack,
    output logic              err,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic [W-1:0]      reg_d,
    input  logic [W-1:0]      reg_q,
    output logic              busy,
    output logic [IDXW-1:0]   owner
);

    ctrl_state_t     state_q;
    logic [IDXW-1:0] owner_q, ptr_q, winner;
    logic [W-1:0]    regd_q, win_data;
    logic [N-1:0]    ack_q;
    logic            err_q, sticky_q;
    logic            any, mism;

    rr_arbitro #(.N(N), .IDXW(IDXW)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == IDXW'(i)) win_data = wdata[i*W +: W];
        end
    end

    assign mism = (reg_q != regd_q);

    // reg_d only moves on the IDLE->WRITE edge so the registrador keeps its
    // content between transactions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            regd_q   <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            // A mismatch in VERIFY beats a same-cycle clear.
            sticky_q <= (sticky_q & ~err_clr) | ((state_q == VERIFY) & mism);
            case (state_q)
                IDLE: begin
                    if (any) begin
                        owner_q <= winner;
                        regd_q  <= win_data;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    state_q <= VERIFY;
                end
                VERIFY: begin
                    for (int i = 0; i < N; i++) begin
                        ack_q[i] <= (owner_q == IDXW'(i));
                    end
                    err_q   <= mism;
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    ptr_q   <= (owner_q == IDXW'(N-1)) ? '0 : owner_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign reg_d      = regd_q;
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;

endmodule

// File: tb/tb_registrador_ctrl.sv
// Directed bench for registrador_ctrl with a behavioural registrador on reg_d/reg_q.
module tb_registrador_ctrl;

    localparam int N = 4;
    localparam int W = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  wdata;
    logic [N-1:0]    ack;
    logic            err, err_sticky, err_clr;
    logic [W-1:0]    reg_d, reg_q;
    logic            busy;
    logic [IDXW-1:0] owner;

    logic [W-1:0]    rq_model = '0;
    logic            force_q;

    int nchk = 0;
    int nerr = 0;

    registrador_ctrl #(.N(N), .W(W), .IDXW(IDXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wdata      (wdata),
        .ack        (ack),
        .err        (err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .reg_d      (reg_d),
        .reg_q      (reg_q),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    // The registrador itself: no enable, no reset.
    always @(posedge clk) rq_model <= reg_d;
    assign reg_q = force_q ? 4'b0000 : rq_model;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; req = '0; wdata = '0; err_clr = 1'b0; force_q = 1'b0;

        // reset
        #12 rst = 1'b1;
        chk("rst_reg_d", 32'(reg_d), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_sticky", 32'(err_sticky), 0);
        chk("rst_owner", 32'(owner), 0);
        tick();
        for (int c = 0; c < 20; c++) begin
            chk("idle_reg_d", 32'(reg_d), 0);
            chk("idle_busy", 32'(busy), 0);
            tick();
        end

        // single request from requester 2
        wdata[2*W +: W] = 4'b1010;
        req = 4'b0100;
        tick();
        chk("s_owner", 32'(owner), 2);
        chk("s_reg_d", 32'(reg_d), 32'hA);
        chk("s_busy1", 32'(busy), 1);
        tick();
        chk("s_reg_q", 32'(reg_q), 32'hA);
        chk("s_ack_early", 32'(ack), 0);
        tick();
        chk("s_ack", 32'(ack), 32'b0100);
        chk("s_err", 32'(err), 0);
        req = '0;
        tick();
        chk("s_busy4", 32'(busy), 0);
        chk("s_ack_off", 32'(ack), 0);

        // fairness: restart from pointer 0 with everyone requesting
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) wdata[i*W +: W] = 4'(i + 5);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            automatic int exp_o = k % N;
            tick();
            chk("rr_owner", 32'(owner), 32'(exp_o));
            chk("rr_reg_d", 32'(reg_d), 32'(exp_o + 5));
            tick();
            chk("rr_reg_q", 32'(reg_q), 32'(exp_o + 5));
            tick();
            chk("rr_ack", 32'(ack), 32'(1 << exp_o));
            if (k == 4) req = '0;
            tick();
            chk("rr_idle", 32'(busy), 0);
        end

        // verify mismatch on a write of 1111 (pointer now 1)
        wdata[1*W +: W] = 4'b1111;
        req = 4'b0010;
        tick();
        chk("e_reg_d", 32'(reg_d), 32'hF);
        force_q = 1'b1;
        tick();
        tick();
        chk("e_ack", 32'(ack), 32'b0010);
        chk("e_err", 32'(err), 1);
        chk("e_sticky", 32'(err_sticky), 1);
        req = '0;
        force_q = 1'b0;
        tick();
        chk("e_err_clear", 32'(err), 0);
        chk("e_sticky_hold", 32'(err_sticky), 1);
        tick();
        chk("e_sticky_hold2", 32'(err_sticky), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("e_sticky_clr", 32'(err_sticky), 0);

        // err_clr and mismatch in the same cycle: mismatch wins
        req = 4'b0010;
        tick();
        force_q = 1'b1;
        err_clr = 1'b1;
        tick();
        tick();
        chk("ec_err", 32'(err), 1);
        chk("ec_sticky", 32'(err_sticky), 1);
        force_q = 1'b0;
        req = '0;
        tick();
        chk("ec_clear", 32'(err_sticky), 0);
        err_clr = 1'b0;

        // req[1] dropped in WRITE, wdata changed mid-transaction
        wdata[1*W +: W] = 4'b0011;
        req = 4'b0010;
        tick();
        chk("d_owner", 32'(owner), 1);
        chk("d_reg_d", 32'(reg_d), 32'h3);
        req = '0;
        wdata[1*W +: W] = 4'b1100;
        tick();
        chk("d_reg_d_v", 32'(reg_d), 32'h3);
        tick();
        chk("d_ack", 32'(ack), 32'b0010);
        chk("d_err", 32'(err), 0);
        tick();
        chk("d_reg_d_hold", 32'(reg_d), 32'h3);
        tick();
        chk("d_reg_d_hold2", 32'(reg_d), 32'h3);

        // reset during VERIFY, then a pending req[3]
        wdata[0*W +: W] = 4'b0110;
        wdata[3*W +: W] = 4'b1001;
        req = 4'b0001;
        tick();
        chk("r_owner0", 32'(owner), 0);
        tick();
        chk("r_in_verify", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk("r_busy", 32'(busy), 0);
        chk("r_reg_d", 32'(reg_d), 0);
        chk("r_ack", 32'(ack), 0);
        req = 4'b1000;
        tick();
        chk("r_ack_hold", 32'(ack), 0);
        chk("r_reg_q", 32'(reg_q), 0);
        rst = 1'b1;
        tick();
        chk("r_owner3", 32'(owner), 3);
        chk("r_reg_d3", 32'(reg_d), 32'h9);
        tick();
        chk("r_reg_q3", 32'(reg_q), 32'h9);
        tick();
        chk("r_ack3", 32'(ack), 32'b1000);
        req = '0;
        tick();
        chk("r_done", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
